// File: rtl/grid_pixel_sink.sv
// grid_pixel_sink: receiving end of a raster pixel stream (x, y, colour).
// Tracks the expected raster position, turns in-order pixels into linear
// framebuffer write beats (addr = row_base + x) and drops out-of-order pixels,
// flagging them on seq_error. A pixel at (0,0) arriving out of order is taken
// as a new frame start (resync).
//
// Optional feature: define GRID_SINK_ERRCNT_EN to get a saturating 8-bit
// dropped-pixel counter on err_count; otherwise err_count is tied to zero.
//
// Handshake: a beat transfers on an interface in the cycle where valid and
// ready are both high at the rising clock edge. Once raised, out_valid stays
// high and out_addr/out_colour/out_last stay stable until out_ready is seen.
// in_ready depends only on out_valid and out_ready, never on in_valid.

module grid_pixel_sink #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int COLOUR_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [WIDTH-1:0]        x_max,
  input  logic [WIDTH-1:0]        y_max,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_x,
  input  logic [WIDTH-1:0]        in_y,
  input  logic [COLOUR_WIDTH-1:0] in_colour,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [COLOUR_WIDTH-1:0] out_colour,
  output logic                    out_last,
  output logic                    frame_done,
  output logic                    seq_error,
  input  logic                    clear_err,
  output logic [7:0]              err_count
);

  localparam logic [WIDTH-1:0]      ONE_W = WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  // Raster tracker state
  logic [WIDTH-1:0]        exp_x_q, exp_x_d;
  logic [WIDTH-1:0]        exp_y_q, exp_y_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic [WIDTH-1:0]        xm_s_q, xm_s_d;
  logic [WIDTH-1:0]        ym_s_q, ym_s_d;

  // One-entry output register
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [COLOUR_WIDTH-1:0] out_colour_q, out_colour_d;
  logic                    out_last_q, out_last_d;
  logic                    frame_done_q, frame_done_d;
  logic                    seq_error_q, seq_error_d;

  // Decode of the current input pixel
  logic                    in_ready_c;
  logic                    accept;
  logic                    at_origin;
  logic                    is_match;
  logic                    in_zero;
  logic                    resync;
  logic                    drop;
  logic                    fwd;
  logic                    use_live;
  logic [WIDTH-1:0]        xm_eff;
  logic [WIDTH-1:0]        ym_eff;
  logic [WIDTH-1:0]        base_x;
  logic [WIDTH-1:0]        base_y;
  logic [ADDR_WIDTH-1:0]   base_rb;
  logic                    is_last;

  // Classify the incoming pixel: in-order, resync at (0,0), or dropped
  always_comb begin
    in_ready_c = ~out_valid_q | out_ready;
    accept     = in_valid & in_ready_c;
    at_origin  = (exp_x_q == '0) && (exp_y_q == '0);
    is_match   = (in_x == exp_x_q) && (in_y == exp_y_q);
    in_zero    = (in_x == '0) && (in_y == '0);
    resync     = accept & ~is_match & in_zero;
    drop       = accept & ~is_match & ~in_zero;
    fwd        = accept & (is_match | in_zero);
    // A frame's dimensions are taken live at its first pixel and frozen
    // for the rest of the frame.
    use_live   = at_origin | resync;
    xm_eff     = use_live ? x_max : xm_s_q;
    ym_eff     = use_live ? y_max : ym_s_q;
    // A resync restarts the frame, so the advance starts from the origin.
    base_x     = resync ? '0 : exp_x_q;
    base_y     = resync ? '0 : exp_y_q;
    base_rb    = resync ? '0 : row_base_q;
    is_last    = (base_x == xm_eff) && (base_y == ym_eff);
  end

  // Next tracker position and frozen frame size
  always_comb begin
    exp_x_d    = exp_x_q;
    exp_y_d    = exp_y_q;
    row_base_d = row_base_q;
    xm_s_d     = use_live ? x_max : xm_s_q;
    ym_s_d     = use_live ? y_max : ym_s_q;
    if (fwd) begin
      if (base_x < xm_eff) begin
        exp_x_d    = base_x + ONE_W;
        exp_y_d    = base_y;
        row_base_d = base_rb;
      end else if (base_y < ym_eff) begin
        exp_x_d    = '0;
        exp_y_d    = base_y + ONE_W;
        row_base_d = base_rb + ADDR_WIDTH'(xm_eff) + ONE_A;
      end else begin
        exp_x_d    = '0;
        exp_y_d    = '0;
        row_base_d = '0;
      end
    end
  end

  // Output beat register, end-of-frame pulse and sticky error flag
  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_colour_d = out_colour_q;
    out_last_d   = out_last_q;
    if (fwd) begin
      out_valid_d  = 1'b1;
      out_addr_d   = base_rb + ADDR_WIDTH'(in_x);
      out_colour_d = in_colour;
      out_last_d   = is_last;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
    end
    frame_done_d = out_valid_q & out_ready & out_last_q;
    // clear_err takes priority over an error raised in the same cycle
    seq_error_d  = clear_err ? 1'b0 : (seq_error_q | resync | drop);
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exp_x_q      <= '0;
      exp_y_q      <= '0;
      row_base_q   <= '0;
      xm_s_q       <= '0;
      ym_s_q       <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_colour_q <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      seq_error_q  <= 1'b0;
    end else begin
      exp_x_q      <= exp_x_d;
      exp_y_q      <= exp_y_d;
      row_base_q   <= row_base_d;
      xm_s_q       <= xm_s_d;
      ym_s_q       <= ym_s_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_colour_q <= out_colour_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      seq_error_q  <= seq_error_d;
    end
  end

`ifdef GRID_SINK_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating count of dropped pixels; resyncs are not counted
  always_comb begin
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = 8'd0;
    end else if (drop && (err_count_q != 8'hff)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

  assign in_ready   = in_ready_c;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_colour = out_colour_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign seq_error  = seq_error_q;

endmodule
